// File: rtl/lcd_rx_timing.sv
// DE-mode RGB receiver: recovers pixel coordinates from in_de, finds frames from long DE-low gaps,
// measures line/frame size against the expected format and reports lock.
module lcd_rx_timing #(
  parameter logic [10:0] H_DISP      = 11'd480,
  parameter logic [10:0] V_DISP      = 11'd272,
  parameter logic [13:0] VBLANK_MIN  = 14'd1024,
  parameter logic [1:0]  LOCK_FRAMES = 2'd2
) (
  input  logic        lcd_clk,
  input  logic        sys_rst,
  input  logic        in_de,
  input  logic [23:0] in_rgb,
  output logic        pix_valid,
  output logic [23:0] pix_data,
  output logic [10:0] pix_xpos,
  output logic [10:0] pix_ypos,
  output logic        sof,
  output logic        eol,
  output logic        eof,
  output logic        locked,
  output logic [10:0] meas_width,
  output logic [10:0] meas_height,
  output logic        err_width,
  output logic        err_height
);

  localparam logic [10:0] CntMax = 11'h7ff;

  typedef enum logic [1:0] {StSeek, StArmed, StActive} state_e;

  state_e      state_q, state_d;
  logic        de_s1_q;
  logic [23:0] rgb_s1_q;
  logic [13:0] gap_cnt_q, gap_cnt_d;
  logic [10:0] x_cnt_q, x_cnt_d;
  logic [10:0] y_cnt_q, y_cnt_d;
  logic [1:0]  good_cnt_q, good_cnt_d;
  logic        frame_bad_q, frame_bad_d;

  logic        pix_valid_q, pix_valid_d;
  logic [23:0] pix_data_q, pix_data_d;
  logic [10:0] pix_xpos_q, pix_xpos_d;
  logic [10:0] pix_ypos_q, pix_ypos_d;
  logic        sof_q, sof_d;
  logic        eol_q, eol_d;
  logic        eof_q, eof_d;
  logic        locked_q, locked_d;
  logic [10:0] meas_width_q, meas_width_d;
  logic [10:0] meas_height_q, meas_height_d;
  logic        err_width_q, err_width_d;
  logic        err_height_q, err_height_d;

  logic        vblank_hit, line_end, start, capture, width_bad, frame_good;
  logic [10:0] y_cur, line_len;
  logic [1:0]  good_inc;

  assign vblank_hit = !de_s1_q && (gap_cnt_q == VBLANK_MIN - 14'd1);
  // in_de is one cycle ahead of de_s1_q, so a falling edge there marks the last pixel
  assign line_end   = de_s1_q && !in_de;
  assign start      = (state_q == StArmed) && de_s1_q;
  assign capture    = start || ((state_q == StActive) && de_s1_q);
  assign y_cur      = start ? 11'd0 : y_cnt_q;
  assign line_len   = (x_cnt_q == CntMax) ? CntMax : x_cnt_q + 11'd1;
  assign width_bad  = (line_len != H_DISP);
  assign frame_good = !frame_bad_q && (y_cnt_q == V_DISP);
  assign good_inc   = (good_cnt_q >= LOCK_FRAMES) ? good_cnt_q : good_cnt_q + 2'd1;

  always_comb begin
    if (de_s1_q)                      gap_cnt_d = '0;
    else if (gap_cnt_q >= VBLANK_MIN) gap_cnt_d = VBLANK_MIN;
    else                              gap_cnt_d = gap_cnt_q + 14'd1;

    x_cnt_d = x_cnt_q;
    if (line_end)                             x_cnt_d = '0;
    else if (de_s1_q && (x_cnt_q != CntMax))  x_cnt_d = x_cnt_q + 11'd1;

    y_cnt_d = y_cur;
    if (line_end && (y_cur != CntMax)) y_cnt_d = y_cur + 11'd1;

    state_d       = state_q;
    frame_bad_d   = frame_bad_q;
    good_cnt_d    = good_cnt_q;
    pix_valid_d   = 1'b0;
    pix_data_d    = pix_data_q;
    pix_xpos_d    = pix_xpos_q;
    pix_ypos_d    = pix_ypos_q;
    sof_d         = 1'b0;
    eol_d         = 1'b0;
    eof_d         = 1'b0;
    err_width_d   = 1'b0;
    err_height_d  = 1'b0;
    locked_d      = locked_q;
    meas_width_d  = meas_width_q;
    meas_height_d = meas_height_q;

    if (capture) begin
      pix_valid_d = 1'b1;
      pix_data_d  = rgb_s1_q;
      pix_xpos_d  = x_cnt_q;
      pix_ypos_d  = y_cur;
      sof_d       = start;
      state_d     = StActive;
      if (start) frame_bad_d = 1'b0;
      if (line_end) begin
        eol_d        = 1'b1;
        meas_width_d = line_len;
        err_width_d  = width_bad;
        if (width_bad) frame_bad_d = 1'b1;
      end
    end

    case (state_q)
      StSeek: begin
        if (vblank_hit) state_d = StArmed;
      end
      StActive: begin
        if (vblank_hit) begin
          eof_d         = 1'b1;
          meas_height_d = y_cnt_q;
          state_d       = StArmed;
          if (frame_good) begin
            good_cnt_d = good_inc;
            locked_d   = (good_inc >= LOCK_FRAMES);
          end else begin
            err_height_d = (y_cnt_q != V_DISP);
            good_cnt_d   = '0;
            locked_d     = 1'b0;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge lcd_clk) begin
    if (sys_rst) begin
      state_q       <= StSeek;
      de_s1_q       <= 1'b0;
      rgb_s1_q      <= '0;
      gap_cnt_q     <= '0;
      x_cnt_q       <= '0;
      y_cnt_q       <= '0;
      good_cnt_q    <= '0;
      frame_bad_q   <= 1'b0;
      pix_valid_q   <= 1'b0;
      pix_data_q    <= '0;
      pix_xpos_q    <= '0;
      pix_ypos_q    <= '0;
      sof_q         <= 1'b0;
      eol_q         <= 1'b0;
      eof_q         <= 1'b0;
      locked_q      <= 1'b0;
      meas_width_q  <= '0;
      meas_height_q <= '0;
      err_width_q   <= 1'b0;
      err_height_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      de_s1_q       <= in_de;
      rgb_s1_q      <= in_rgb;
      gap_cnt_q     <= gap_cnt_d;
      x_cnt_q       <= x_cnt_d;
      y_cnt_q       <= y_cnt_d;
      good_cnt_q    <= good_cnt_d;
      frame_bad_q   <= frame_bad_d;
      pix_valid_q   <= pix_valid_d;
      pix_data_q    <= pix_data_d;
      pix_xpos_q    <= pix_xpos_d;
      pix_ypos_q    <= pix_ypos_d;
      sof_q         <= sof_d;
      eol_q         <= eol_d;
      eof_q         <= eof_d;
      locked_q      <= locked_d;
      meas_width_q  <= meas_width_d;
      meas_height_q <= meas_height_d;
      err_width_q   <= err_width_d;
      err_height_q  <= err_height_d;
    end
  end

  assign pix_valid   = pix_valid_q;
  assign pix_data    = pix_data_q;
  assign pix_xpos    = pix_xpos_q;
  assign pix_ypos    = pix_ypos_q;
  assign sof         = sof_q;
  assign eol         = eol_q;
  assign eof         = eof_q;
  assign locked      = locked_q;
  assign meas_width  = meas_width_q;
  assign meas_height = meas_height_q;
  assign err_width   = err_width_q;
  assign err_height  = err_height_q;

endmodule
